// File: rtl/vend_ctrl.sv
// vend_ctrl: sequencing controller for the vending machine price datapath.
// Accumulates coins into a 4-bit credit (5-cent units), vends once the
// credit reaches PRICE, and returns change or cancel refunds one unit at a
// time over a valid/ready handshake.
//
// Ports:
//   i_clk, i_rst      clock (rising edge), async active-high reset
//   i_coin_5/10/20    1-cycle coin pulses (+1/+2/+4 units)
//   i_cancel          1-cycle pulse: refund current credit
//   i_change_ready    coin-return mechanism accepts one unit
//   o_credit          current credit in units
//   o_vend            1-cycle pulse: release item
//   o_change_valid    one unit offered for return
//   o_change_cnt      units still to return
//   o_accept          high only in IDLE (coins counted only then)
//   o_coin_err        1-cycle pulse: a coin pulse was rejected
module vend_ctrl #(
    parameter int PRICE = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_coin_5,
    input  logic       i_coin_10,
    input  logic       i_coin_20,
    input  logic       i_cancel,
    input  logic       i_change_ready,
    output logic [3:0] o_credit,
    output logic       o_vend,
    output logic       o_change_valid,
    output logic [3:0] o_change_cnt,
    output logic       o_accept,
    output logic       o_coin_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_VEND,
        S_RETURN
    } state_t;

    localparam logic [3:0] PRICE_U = 4'(PRICE);

    state_t     state_q, state_d;
    logic [3:0] credit_q, credit_d;
    logic [3:0] cnt_q, cnt_d;
    logic       vend_q, vend_d;
    logic       err_q, err_d;

    logic       coin_any, coin_multi;
    logic [3:0] coin_val;
    logic [3:0] cand;
    logic [3:0] sub_a;
    logic [3:0] diff;
    logic       borrow;
    logic       valid;

    always_comb begin
        coin_val = '0;
        unique case ({i_coin_20, i_coin_10, i_coin_5})
            3'b001:  coin_val = 4'd1;
            3'b010:  coin_val = 4'd2;
            3'b100:  coin_val = 4'd4;
            default: coin_val = '0;
        endcase
    end

    assign coin_any   = i_coin_5 | i_coin_10 | i_coin_20;
    assign coin_multi = (i_coin_5 & i_coin_10) | (i_coin_5 & i_coin_20) |
                        (i_coin_10 & i_coin_20);

    assign cand = credit_q + coin_val;

    // One shared subtractor: in IDLE it tests the candidate credit against
    // the price (borrow), in VEND it produces the change (diff).
    assign sub_a = (state_q == S_VEND) ? credit_q : cand;
    assign {borrow, diff} = {1'b0, sub_a} - {1'b0, PRICE_U};

    assign valid = (state_q == S_RETURN) && (cnt_q != '0);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            credit_q <= '0;
            cnt_q    <= '0;
            vend_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            cnt_q    <= cnt_d;
            vend_q   <= vend_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        cnt_d    = cnt_q;
        vend_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_cancel) begin
                    // Cancel wins; any coin in the same cycle is rejected.
                    err_d = coin_any;
                    if (credit_q != '0) begin
                        cnt_d    = credit_q;
                        credit_d = '0;
                        state_d  = S_RETURN;
                    end
                end else if (coin_multi) begin
                    err_d = 1'b1;
                end else if (coin_any) begin
                    credit_d = cand;
                    if (!borrow) begin
                        vend_d  = 1'b1;
                        state_d = S_VEND;
                    end
                end
            end

            S_VEND: begin
                err_d    = coin_any;
                cnt_d    = diff;
                credit_d = '0;
                state_d  = (diff != '0) ? S_RETURN : S_IDLE;
            end

            S_RETURN: begin
                err_d = coin_any;
                if (valid && i_change_ready) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = S_IDLE;
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign o_credit       = credit_q;
    assign o_vend         = vend_q;
    assign o_change_cnt   = cnt_q;
    assign o_coin_err     = err_q;
    assign o_change_valid = valid;
    assign o_accept       = (state_q == S_IDLE);

endmodule

// File: tb/tb_vend_ctrl.sv
module tb_vend_ctrl;

    localparam int PRICE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       c5, c10, c20, cancel, ready;
    logic [3:0] credit, cnt;
    logic       vend, cv, accept, cerr;

    // {credit, change_cnt, vend, change_valid, accept, coin_err}
    logic [11:0] outs;
    logic [11:0] exp;
    assign outs = {credit, cnt, vend, cv, accept, cerr};

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vend_ctrl #(.PRICE(PRICE)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_coin_5       (c5),
        .i_coin_10      (c10),
        .i_coin_20      (c20),
        .i_cancel       (cancel),
        .i_change_ready (ready),
        .o_credit       (credit),
        .o_vend         (vend),
        .o_change_valid (cv),
        .o_change_cnt   (cnt),
        .o_accept       (accept),
        .o_coin_err     (cerr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a5, input logic a10, input logic a20, input logic acan);
        c5 = a5; c10 = a10; c20 = a20; cancel = acan;
    endtask

    // Present inputs for exactly one active edge, then clear them.
    task automatic step(input logic a5, input logic a10, input logic a20, input logic acan);
        drive(a5, a10, a20, acan);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; ready = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        rst = 1'b0;
        tick();
        exp = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL reset_state: got %h want %h", outs, exp); end
    endtask

    task automatic test_exact_price();
        step(1'b0, 1'b0, 1'b1, 1'b0);
        exp = {4'd4, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL exact_vend: got %h want %h", outs, exp); end
        tick();
        exp = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL exact_idle: got %h want %h", outs, exp); end
    endtask

    task automatic test_vend_change();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {4'd2, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL chg_credit2: got %h want %h", outs, exp); end
        step(1'b1, 1'b0, 1'b0, 1'b0);
        exp = {4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL chg_credit3: got %h want %h", outs, exp); end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        exp = {4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL chg_vend: got %h want %h", outs, exp); end
        ready = 1'b1;
        tick();
        exp = {4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL chg_return3: got %h want %h", outs, exp); end
        for (int i = 2; i >= 0; i--) begin
            tick();
            exp = {4'd0, 4'(i), 1'b0, (i != 0), (i == 0), 1'b0};
            n_cmp++;
            if (outs !== exp) begin n_bad++; $display("FAIL chg_count%0d: got %h want %h", i, outs, exp); end
        end
        ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [4:0] pat;
        int         remain;
        pat    = 5'b01001;   // ready sequence 0,1,0,0,1 (bit 4 first)
        remain = 2;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        for (int i = 4; i >= 0; i--) begin
            ready = pat[i];
            tick();
            if (pat[i]) remain--;
            exp = {4'd0, 4'(remain), 1'b0, (remain != 0), (remain == 0), 1'b0};
            n_cmp++;
            if (outs !== exp) begin n_bad++; $display("FAIL bp_step%0d: got %h want %h", 4 - i, outs, exp); end
        end
        ready = 1'b0;
    endtask

    task automatic test_cancel();
        int got;
        bit saw_vend;
        got = 0; saw_vend = 1'b0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        exp = {4'd0, 4'd3, 1'b0, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL cancel_refund: got %h want %h", outs, exp); end
        ready = 1'b1;
        for (int i = 0; i < 10 && !accept; i++) begin
            if (cv) got++;
            if (vend) saw_vend = 1'b1;
            tick();
        end
        ready = 1'b0;
        n_cmp++;
        if (got !== 3 || saw_vend || !accept) begin
            n_bad++; $display("FAIL cancel_units: got %0d units vend=%0d accept=%0d want 3 units vend=0 accept=1",
                              got, saw_vend, accept);
        end
    endtask

    task automatic test_errors();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        exp = {4'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL err_multi: got %h want %h", outs, exp); end
        tick();
        exp = {4'd1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL err_pulse_len: got %h want %h", outs, exp); end
        step(1'b0, 1'b0, 1'b1, 1'b1);
        exp = {4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL err_cancel_coin: got %h want %h", outs, exp); end
        step(1'b0, 1'b1, 1'b0, 1'b0);
        exp = {4'd0, 4'd1, 1'b0, 1'b1, 1'b0, 1'b1};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL err_coin_return: got %h want %h", outs, exp); end
        ready = 1'b1;
        tick();
        ready = 1'b0;
        exp = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL err_back_idle: got %h want %h", outs, exp); end
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL err_cancel_zero: got %h want %h", outs, exp); end
    endtask

    task automatic test_reset_mid_return();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        exp = {4'd0, 4'd2, 1'b0, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL rst_pre: got %h want %h", outs, exp); end
        #2 rst = 1'b1;
        #1;
        exp = {4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL rst_async: got %h want %h", outs, exp); end
        #2 rst = 1'b0;
        tick();
        n_cmp++;
        if (outs !== exp) begin n_bad++; $display("FAIL rst_after: got %h want %h", outs, exp); end
    endtask

    // Transaction-level model: running credit sum; a purchase completes when
    // the sum reaches PRICE and returns sum-PRICE units; a cancel returns sum.
    task automatic test_random();
        int sum, want_units, got, pick, v, waited;
        bit stray;
        sum = 0;
        for (int t = 0; t < 120; t++) begin
            pick = int'($urandom_range(0, 9));
            want_units = -1;
            if (pick == 0) begin
                step(1'b1, 1'b0, 1'b1, 1'b0);
                n_cmp++;
                if (credit !== 4'(sum) || cerr !== 1'b1) begin
                    n_bad++; $display("FAIL rnd_multi: credit %0d err %0d want credit %0d err 1", credit, cerr, sum);
                end
            end else if (pick == 1) begin
                step(1'b0, 1'b0, 1'b0, 1'b1);
                want_units = sum;
                sum = 0;
            end else begin
                v = 1 << $urandom_range(0, 2);
                step(v == 1, v == 2, v == 4, 1'b0);
                sum += v;
                n_cmp++;
                if (credit !== 4'(sum) || vend !== (sum >= PRICE)) begin
                    n_bad++; $display("FAIL rnd_coin: credit %0d vend %0d want credit %0d vend %0d",
                                      credit, vend, sum, (sum >= PRICE));
                end
                if (sum >= PRICE) begin
                    want_units = sum - PRICE;
                    sum = 0;
                end
            end
            if (want_units >= 0) begin
                got = 0; waited = 0;
                while (!accept && waited < 60) begin
                    ready = 1'($urandom_range(0, 1));
                    stray = ($urandom_range(0, 3) == 0);
                    if (cv && ready) got++;
                    drive(stray, 1'b0, 1'b0, 1'b0);
                    tick();
                    drive(1'b0, 1'b0, 1'b0, 1'b0);
                    waited++;
                    n_cmp++;
                    if (cerr !== stray) begin
                        n_bad++; $display("FAIL rnd_stray_err: err %0d want %0d", cerr, stray);
                    end
                end
                ready = 1'b0;
                n_cmp++;
                if (got !== want_units || credit !== 4'd0 || !accept) begin
                    n_bad++; $display("FAIL rnd_units: got %0d units credit %0d accept %0d want %0d units credit 0 accept 1",
                                      got, credit, accept, want_units);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_exact_price();
        test_vend_change();
        test_backpressure();
        test_cancel();
        test_errors();
        test_reset_mid_return();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
